// File: rtl/cla_alu_pipe.sv
// Two-stage pipelined ALU (bit slices + two-level carry lookahead); result valid one edge after operand accept.
// Backpressure: out_ready low holds stage 2, then stage 1; in_ready is combinational from out_ready.
module cla_alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NGRP = WIDTH / 4;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic             s1_take, s2_take;
    logic [WIDTH-1:0] b_eff, g, p, sum, alu_res;
    logic [NGRP-1:0]  grp_g, grp_p;
    logic [NGRP:0]    grp_c;
    logic [WIDTH:0]   c;
    logic             ovf, slt;

    always_comb begin
        s2_take  = !s2_valid_q || out_ready;
        s1_take  = !s1_valid_q || s2_take;
        in_ready = s1_take;
    end

    // Per-bit generate/propagate, then group G/P feeding the second lookahead level.
    always_comb begin
        logic acc, pp;
        b_eff = s1_b_q ^ {WIDTH{s1_op_q[2]}};
        g     = s1_a_q & b_eff;
        p     = s1_a_q ^ b_eff;
        acc   = 1'b0;
        pp    = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
        grp_c[0] = s1_op_q[2];
        for (int k = 0; k < NGRP; k++) begin
            acc = grp_g[k];
            pp  = grp_p[k];
            for (int j = k - 1; j >= 0; j--) begin
                acc = acc | (pp & grp_g[j]);
                pp  = pp & grp_p[j];
            end
            grp_c[k+1] = acc | (pp & grp_c[0]);
        end
        // In-group carries are looked ahead from the incoming group carry.
        for (int k = 0; k < NGRP; k++) begin
            c[4*k] = grp_c[k];
            for (int i = 1; i < 4; i++) begin
                acc = g[4*k+i-1];
                pp  = p[4*k+i-1];
                for (int j = i - 2; j >= 0; j--) begin
                    acc = acc | (pp & g[4*k+j]);
                    pp  = pp & p[4*k+j];
                end
                c[4*k+i] = acc | (pp & grp_c[k]);
            end
        end
        c[WIDTH] = grp_c[NGRP];
    end

    always_comb begin
        sum = p ^ c[WIDTH-1:0];
        ovf = c[WIDTH-1] ^ c[WIDTH];
        slt = sum[WIDTH-1] ^ ovf;
        case (s1_op_q[1:0])
            2'b00:   alu_res = s1_a_q & b_eff;
            2'b01:   alu_res = s1_a_q | b_eff;
            2'b10:   alu_res = sum;
            default: alu_res = {{(WIDTH-1){1'b0}}, slt};
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_take) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d  = in_a;
                s1_b_d  = in_b;
                s1_op_d = in_op;
            end
        end
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        if (s2_take) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d  = alu_res;
                cout_d = c[WIDTH];
                ovf_d  = ovf;
                zero_d = (alu_res == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = res_q;
    assign out_cout   = cout_q;
    assign out_ovf    = ovf_q;
    assign out_zero   = zero_q;

endmodule

// File: tb/tb_cla_alu_pipe.sv
// Scoreboard bench for cla_alu_pipe: directed vectors plus a behavioural adder model.
module tb_cla_alu_pipe;

    typedef struct packed {
        logic [31:0] r;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [2:0]  in_op;
    logic        out_cout, out_ovf, out_zero;

    int   n_chk = 0;
    int   n_fail = 0;
    int   accepted = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   out_cycs[$];

    cla_alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cout(out_cout),
        .out_ovf(out_ovf), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        exp_t        e;
        logic [31:0] be;
        logic [32:0] s;
        be     = op[2] ? ~b : b;
        s      = {1'b0, a} + {1'b0, be} + {32'd0, op[2]};
        e.cout = s[32];
        e.ovf  = (a[31] == be[31]) && (s[31] != a[31]);
        case (op[1:0])
            2'b00:   e.r = a & be;
            2'b01:   e.r = a | be;
            2'b10:   e.r = s[31:0];
            default: e.r = {31'd0, s[31] ^ e.ovf};
        endcase
        e.zero = (e.r == 32'd0);
        return e;
    endfunction

    // Monitor: pops one expectation per output handshake.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {8'd0, out_result}, 40'hxx_xxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", {5'd0, out_result, out_cout, out_ovf, out_zero}, {5'd0, e});
            end
            out_cycs.push_back(cyc);
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input exp_t e);
        bit done = 0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                accepted++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 40'd0, 40'd1);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) ok = 1;
        end
        if (!ok) chk("drain_timeout", 40'd0, 40'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_lat();
        @(negedge clk);
        chk("lat_edge_n", {39'd0, out_valid}, 40'd0);
        @(negedge clk);
        chk("lat_edge_n1", {39'd0, out_valid}, 40'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] ops[8];
        logic [31:0] ra, rb;
        int n0;
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b101, 3'b011};
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {3'd0, out_valid, in_ready, out_result, out_cout, out_ovf, out_zero},
            {3'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1});
        reset = 1'b0;
        @(posedge clk);
        #1;

        send(32'hFFFF_FFFF, 32'h0000_0001, 3'b010, '{32'h0, 1'b1, 1'b0, 1'b1});
        check_lat();
        send(32'h8000_0000, 32'h0000_0001, 3'b110, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
        send(32'hFFFF_FFFE, 32'h0000_0003, 3'b111, '{32'h1, 1'b1, 1'b0, 1'b0});
        send(32'h0000_0003, 32'hFFFF_FFFE, 3'b111, '{32'h0, 1'b0, 1'b0, 1'b1});
        send(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, '{32'h00F0_00F0, 1'b1, 1'b0, 1'b0});
        send(32'h1234_0000, 32'h0000_5678, 3'b001, '{32'h1234_5678, 1'b0, 1'b0, 1'b0});
        drain();

        n0 = out_cycs.size();
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = (i == 3) ? ra : $urandom;
            send(ra, rb, ops[i % 8], model(ra, rb, ops[i % 8]));
        end
        drain();
        chk("b2b_count", 40'(out_cycs.size() - n0), 40'd16);
        if (out_cycs.size() - n0 == 16)
            chk("b2b_span", 40'(out_cycs[n0+15] - out_cycs[n0]), 40'd15);

        out_ready = 1'b0;
        n0 = accepted;
        fork
            begin
                send(32'd10, 32'd20, 3'b010, '{32'd30, 1'b0, 1'b0, 1'b0});
                send(32'd5, 32'd5, 3'b110, '{32'd0, 1'b1, 1'b0, 1'b1});
                send(32'hAAAA_0000, 32'h0000_5555, 3'b001, '{32'hAAAA_5555, 1'b0, 1'b0, 1'b0});
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k >= 2) begin
                        chk("stall_hold", {3'd0, out_valid, in_ready, out_result, out_cout, out_ovf, out_zero},
                            {3'd0, 1'b1, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0});
                    end
                end
                chk("stall_accepted", 40'(accepted - n0), 40'd2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(32'd1, 32'd2, 3'b010, '{32'd3, 1'b0, 1'b0, 1'b0});
        send(32'd7, 32'd9, 3'b010, '{32'd16, 1'b0, 1'b0, 1'b0});
        reset = 1'b1;
        #1;
        chk("reset_flush", {37'd0, out_valid, in_ready, out_zero}, {37'd0, 1'b0, 1'b1, 1'b1});
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        send(32'h0000_00FF, 32'h0000_0F00, 3'b001, '{32'h0000_0FFF, 1'b0, 1'b0, 1'b0});
        check_lat();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
